// File: rtl/uart_msg_pkg.sv
// Shared types and helpers for the programmable UART message transmitter.
package uart_msg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic par_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity over the data bits actually sent (bit 7 only counts in 8-bit mode).
  function automatic logic par_bit(input logic [7:0] data, input logic bits8, input logic [1:0] mode);
    logic x;
    x = (^data[6:0]) ^ (bits8 & data[7]);
    case (mode)
      PAR_NONE: return 1'b0;
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_msg_buf.sv
// Message character store: one synchronous write port, one asynchronous read port.
module uart_msg_buf #(
  parameter int ADDR_W = 4
) (
  input  logic              wb_clk_i,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [0:(1<<ADDR_W)-1];

  // Buffer write; contents deliberately survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_msg_tx.sv
// Programmable UART message transmitter: sends buf[0..cfg_last] with latched framing config,
// optional repeat, graceful abort at frame boundary.
module uart_msg_tx
  import uart_msg_pkg::*;
#(
  parameter int DIV_W  = 12,
  parameter int ADDR_W = 4
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic              cfg_bits8,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              cfg_repeat,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  input  logic              abort,
  output logic              tx_o,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] char_idx
);

  state_t            r_state, w_state_nx;
  logic              r_tx, w_tx_nx, r_done, w_done_nx, r_busy;
  logic [ADDR_W-1:0] r_idx, w_idx_nx, w_rd_addr, r_last;
  logic [DIV_W-1:0]  r_baud, w_baud_nx, r_div;
  logic [2:0]        r_bit, w_bit_nx, w_last_bit;
  logic [7:0]        r_shift, w_shift_nx, w_rd_data;
  logic              r_par, w_par_nx, r_stop_req, w_stop_req_nx;
  logic              r_bits8, r_stop2, r_repeat;
  logic [1:0]        r_parity, w_parity_ld;
  logic              w_accept, w_bit_end, w_load, w_bits8_ld;

  uart_msg_buf #(.ADDR_W(ADDR_W)) u_buf (
    .wb_clk_i  (wb_clk_i),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_accept   = (r_state == IDLE) && start && !abort;
  assign w_bit_end  = (r_baud == r_div);
  assign w_last_bit = r_bits8 ? 3'd7 : 3'd6;
  // Address of the next character to load: 0 on accept or wrap, else the following index.
  assign w_rd_addr  = ((r_state == IDLE) || (r_idx == r_last)) ? {ADDR_W{1'b0}} : r_idx + 1'b1;
  // The first frame is loaded before cfg is latched, so it uses the live inputs.
  assign w_bits8_ld  = (r_state == IDLE) ? cfg_bits8  : r_bits8;
  assign w_parity_ld = (r_state == IDLE) ? cfg_parity : r_parity;

  // Next-state, line level and datapath updates.
  always_comb begin
    w_state_nx    = r_state;
    w_tx_nx       = r_tx;
    w_done_nx     = 1'b0;
    w_idx_nx      = r_idx;
    w_baud_nx     = w_bit_end ? {DIV_W{1'b0}} : r_baud + 1'b1;
    w_bit_nx      = r_bit;
    w_shift_nx    = r_shift;
    w_load        = 1'b0;
    w_stop_req_nx = r_stop_req | abort;
    case (r_state)
      IDLE: begin
        w_baud_nx     = {DIV_W{1'b0}};
        w_stop_req_nx = 1'b0;
        w_tx_nx       = 1'b1;
        if (w_accept) begin
          w_state_nx = START;
          w_tx_nx    = 1'b0;
          w_idx_nx   = {ADDR_W{1'b0}};
          w_load     = 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nx = DATA;
          w_tx_nx    = r_shift[0];
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = 3'd0;
        end else begin
          w_state_nx = START;
        end
      end
      DATA: begin
        if (!w_bit_end) begin
          w_state_nx = DATA;
        end else if (r_bit != w_last_bit) begin
          w_tx_nx    = r_shift[0];
          w_shift_nx = {1'b0, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
        end else if (par_en(r_parity)) begin
          w_state_nx = PARITY;
          w_tx_nx    = r_par;
        end else begin
          w_state_nx = STOP;
          w_tx_nx    = 1'b1;
          w_bit_nx   = 3'd0;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nx = STOP;
          w_tx_nx    = 1'b1;
          w_bit_nx   = 3'd0;
        end else begin
          w_state_nx = PARITY;
        end
      end
      STOP: begin
        if (!w_bit_end) begin
          w_state_nx = STOP;
        end else if (r_stop2 && (r_bit == 3'd0)) begin
          w_bit_nx = 3'd1;
        end else if (r_stop_req || abort) begin
          w_state_nx = IDLE;
          w_tx_nx    = 1'b1;
          w_done_nx  = 1'b1;
        end else if ((r_idx != r_last) || r_repeat) begin
          w_state_nx = START;
          w_tx_nx    = 1'b0;
          w_idx_nx   = w_rd_addr;
          w_load     = 1'b1;
        end else begin
          w_state_nx = IDLE;
          w_tx_nx    = 1'b1;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
    if (w_load) begin
      w_shift_nx = w_rd_data;
      w_par_nx   = par_bit(w_rd_data, w_bits8_ld, w_parity_ld);
    end else begin
      w_par_nx   = r_par;
    end
  end

  // State, line and datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_idx      <= {ADDR_W{1'b0}};
      r_baud     <= {DIV_W{1'b0}};
      r_bit      <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_stop_req <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_tx       <= w_tx_nx;
      r_done     <= w_done_nx;
      r_busy     <= (w_state_nx != IDLE);
      r_idx      <= w_idx_nx;
      r_baud     <= w_baud_nx;
      r_bit      <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_par      <= w_par_nx;
      r_stop_req <= w_stop_req_nx;
    end
  end

  // Configuration snapshot taken on the start-accept edge.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      r_div    <= {DIV_W{1'b0}};
      r_last   <= {ADDR_W{1'b0}};
      r_bits8  <= 1'b0;
      r_parity <= 2'b00;
      r_stop2  <= 1'b0;
      r_repeat <= 1'b0;
    end else if (w_accept) begin
      r_div    <= cfg_div;
      r_last   <= cfg_last;
      r_bits8  <= cfg_bits8;
      r_parity <= cfg_parity;
      r_stop2  <= cfg_stop2;
      r_repeat <= cfg_repeat;
    end
  end

  assign tx_o     = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign char_idx = r_idx;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench: a per-cycle line model built from the framing rules, checked every cycle.
module tb_uart_msg_tx;

  logic        wb_clk_i = 1'b0;
  logic        rst_n;
  logic [11:0] cfg_div;
  logic [3:0]  cfg_last;
  logic        cfg_bits8, cfg_stop2, cfg_repeat;
  logic [1:0]  cfg_parity;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        start, abort;
  logic        tx_o, busy, done;
  logic [3:0]  char_idx;

  uart_msg_tx #(.DIV_W(12), .ADDR_W(4)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_last(cfg_last),
    .cfg_bits8(cfg_bits8), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_repeat(cfg_repeat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .abort(abort),
    .tx_o(tx_o), .busy(busy), .done(done), .char_idx(char_idx)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic       vld;
    logic       tx;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mq[$];
  int         m_nbusy;
  logic [3:0] m_idx = 4'd0;
  logic [7:0] mem [16];
  int         checks = 0;
  int         errors = 0;
  bit         chk_on = 1'b0;

  int         t_div, t_last;
  logic       t_bits8, t_stop2, t_repeat;
  logic [1:0] t_par;

  // Every cycle: compare DUT outputs with the next model entry, or the idle line when none is pending.
  always @(negedge wb_clk_i) begin
    exp_t e;
    if (chk_on) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.vld = 1'b1; e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.idx = m_idx;
      end
      if (e.vld) begin
        checks++;
        if ({tx_o, busy, done, char_idx} !== {e.tx, e.busy, e.done, e.idx}) begin
          errors++;
          if (errors < 30)
            $display("FAIL line t=%0t tx/busy/done/idx got %b%b%b %0d want %b%b%b %0d",
                     $time, tx_o, busy, done, char_idx, e.tx, e.busy, e.done, e.idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic bw(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
    mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Expected line, cycle by cycle, from the framing rules; abort_at is the busy cycle abort is high.
  task automatic build_model(input int abort_at);
    int c, idx, nd;
    logic [7:0] d;
    logic p;
    logic b[$];
    exp_t e;
    mq.delete();
    c = 0; idx = 0;
    forever begin
      d = mem[idx];
      nd = t_bits8 ? 8 : 7;
      b.delete();
      b.push_back(1'b0);
      p = 1'b0;
      for (int j = 0; j < nd; j++) begin
        b.push_back(d[j]);
        p ^= d[j];
      end
      if (t_par == 2'b01) b.push_back(p);
      else if (t_par == 2'b10) b.push_back(~p);
      b.push_back(1'b1);
      if (t_stop2) b.push_back(1'b1);
      foreach (b[k]) begin
        for (int r = 0; r <= t_div; r++) begin
          e.vld = 1'b1; e.tx = b[k]; e.busy = 1'b1; e.done = 1'b0; e.idx = idx[3:0];
          mq.push_back(e);
          c++;
        end
      end
      if (abort_at >= 0 && abort_at < c) break;
      if (idx != t_last) idx++;
      else if (t_repeat) idx = 0;
      else break;
      if (c > 20000) break;
    end
    m_nbusy = c;
    e.vld = 1'b1; e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.idx = idx[3:0];
    mq.push_back(e);
  endtask

  // Accept a start and drive the transaction; cfg and start are scrambled while busy.
  task automatic launch(input int abort_at, input int rst_at, input bit wr0, input logic [7:0] wr0_d);
    exp_t e;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    cfg_div = t_div[11:0]; cfg_last = t_last[3:0]; cfg_bits8 = t_bits8;
    cfg_parity = t_par; cfg_stop2 = t_stop2; cfg_repeat = t_repeat;
    e.vld = 1'b1; e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.idx = m_idx;
    exp_q.push_back(e);
    foreach (mq[i]) exp_q.push_back(mq[i]);
    m_idx = mq[mq.size()-1].idx;
    start = 1'b1; abort = 1'b0;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = wr0_d; mem[0] = wr0_d;
    end
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 0; k <= m_nbusy; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        exp_q.delete();
        e.vld = 1'b0;
        exp_q.push_back(e);
        m_idx = 4'd0;
        abort = 1'b0; start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        return;
      end
      abort = (k == abort_at);
      if (k < m_nbusy) begin
        start = ($urandom_range(0, 7) == 0);
        cfg_div = 12'($urandom); cfg_last = 4'($urandom); cfg_bits8 = 1'($urandom);
        cfg_parity = 2'($urandom); cfg_stop2 = 1'($urandom); cfg_repeat = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    logic [9:0]  h_exp;
    logic [10:0] s_exp;
    int          bad, fl, ab;
    rst_n = 1'b0; cfg_div = 12'd0; cfg_last = 4'd0; cfg_bits8 = 1'b0; cfg_parity = 2'b00;
    cfg_stop2 = 1'b0; cfg_repeat = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    start = 1'b0; abort = 1'b0;
    foreach (mem[i]) mem[i] = 8'h00;
    tick();
    chk_on = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) bw(i, 8'h00);

    // "Hi\r\n", 8N1, div 3
    bw(0, 8'h48); bw(1, 8'h69); bw(2, 8'h0D); bw(3, 8'h0A);
    t_div = 3; t_last = 3; t_bits8 = 1'b1; t_par = 2'b00; t_stop2 = 1'b0; t_repeat = 1'b0;
    build_model(-1);
    h_exp = 10'b1010010000;
    for (int b = 0; b < 10; b++) pin("hi_H_bit", mq[4*b].tx, h_exp[b]);
    pin("hi_len", mq.size(), 161);
    pin("hi_done", mq[160].done, 1);
    launch(-1, -1, 1'b0, 8'h00);
    repeat (3) tick();

    // 7E2 at one clock per bit, bit 7 of the stored byte must be ignored
    bw(0, 8'hC1);
    t_div = 0; t_last = 0; t_bits8 = 1'b0; t_par = 2'b01; t_stop2 = 1'b1; t_repeat = 1'b0;
    build_model(-1);
    s_exp = 11'b11010000010;
    for (int b = 0; b < 11; b++) pin("7e2_bit", mq[b].tx, s_exp[b]);
    launch(-1, -1, 1'b0, 8'h00);
    t_par = 2'b10;
    build_model(-1);
    pin("7o2_par", mq[8].tx, 1);
    launch(-1, -1, 1'b0, 8'h00);
    repeat (2) tick();

    // repeat mode, abort inside char 0 of the third pass
    bw(0, 8'h5A); bw(1, 8'hA5);
    t_div = 1; t_last = 1; t_bits8 = 1'b1; t_par = 2'b00; t_stop2 = 1'b0; t_repeat = 1'b1;
    build_model(85);
    pin("rep_len", mq.size(), 101);
    pin("rep_done", mq[100].done, 1);
    bad = 0;
    for (int i = 85; i < mq.size(); i++) if (mq[i].idx != 4'd0) bad++;
    pin("rep_idx_after_abort", bad, 0);
    launch(85, -1, 1'b0, 8'h00);
    repeat (2) tick();

    // reset in the middle of the data bits
    t_div = 2; t_last = 1; t_repeat = 1'b0;
    build_model(-1);
    launch(-1, 11, 1'b0, 8'h00);
    repeat (3) tick();

    // start together with abort while idle is ignored
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0; repeat (3) tick();

    // write to address 0 on the accept edge: old byte goes out, new byte on the next run
    bw(0, 8'h55);
    t_div = 0; t_last = 0; t_bits8 = 1'b1; t_par = 2'b00; t_stop2 = 1'b0; t_repeat = 1'b0;
    build_model(-1);
    pin("wr0_old_bit0", mq[1].tx, 1);
    launch(-1, -1, 1'b1, 8'hAA);
    build_model(-1);
    pin("wr0_new_bit0", mq[1].tx, 0);
    launch(-1, -1, 1'b0, 8'h00);
    repeat (2) tick();

    // randomized transactions
    for (int n = 0; n < 25; n++) begin
      t_div = $urandom_range(0, 3); t_last = $urandom_range(0, 5);
      t_bits8 = 1'($urandom); t_par = 2'($urandom); t_stop2 = 1'($urandom);
      t_repeat = ($urandom_range(0, 2) == 0);
      for (int i = 0; i <= t_last; i++) if ($urandom_range(0, 1) == 1) bw(i, 8'($urandom));
      fl = (2 + (t_bits8 ? 8 : 7) + ((t_par == 2'b01 || t_par == 2'b10) ? 1 : 0) + (t_stop2 ? 1 : 0)) * (t_div + 1);
      if (t_repeat) ab = $urandom_range(0, fl * (t_last + 1) * 3 - 1);
      else if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, fl * (t_last + 1) - 1);
      else ab = -1;
      build_model(ab);
      launch(ab, -1, 1'b0, 8'h00);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
